// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM state, column type and GF(2^8) helpers for the MixColumns datapath.
package aes_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef logic [31:0] col_t;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
endpackage

// File: rtl/mix_single_column.sv
// mix_single_column: combinational MixColumns of one 32-bit column (row 0 in the top byte); inverse select only with MIX_COLUMNS_INV_EN.
module mix_single_column
  import aes_pkg::*;
(
  input  col_t col_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic inv,
`endif
  output col_t col_out
);
  logic [7:0] a0, a1, a2, a3;
  col_t fwd;
  assign {a0, a1, a2, a3} = col_in;
  assign fwd = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
`ifdef MIX_COLUMNS_INV_EN
  col_t bwd;
  assign bwd = {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  assign col_out = inv ? bwd : fwd;
`else
  assign col_out = fwd;
`endif
endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns over a 128-bit state, COLS_PER_CYCLE (1/2/4) columns per cycle, valid/ready on both sides; MIX_COLUMNS_INV_EN adds inv_mode.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);
  localparam int STEPS = 4 / COLS_PER_CYCLE;
  state_t       state;
  logic [1:0]   cnt;
  logic [127:0] buf_q;
  logic [1:0]   col_idx [COLS_PER_CYCLE];
  col_t         mixed [COLS_PER_CYCLE];
`ifdef MIX_COLUMNS_INV_EN
  logic inv_q;
`endif
  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign state_out = buf_q;
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = 2'(int'(cnt) * COLS_PER_CYCLE + g);
    mix_single_column u_col (
      .col_in (buf_q[col_idx[g]*32 +: 32]),
`ifdef MIX_COLUMNS_INV_EN
      .inv    (inv_q),
`endif
      .col_out(mixed[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      buf_q     <= '0;
      out_valid <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q     <= 1'b0;
`endif
    end else if (in_valid && in_ready) begin
      state     <= BUSY;
      cnt       <= '0;
      buf_q     <= state_in;
      out_valid <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q     <= inv_mode;
`endif
    end else if (state == BUSY) begin
      for (int i = 0; i < COLS_PER_CYCLE; i++)
        buf_q[col_idx[i]*32 +: 32] <= mixed[i];
      cnt       <= (cnt == 2'(STEPS - 1)) ? 2'd0 : cnt + 2'd1;
      state     <= (cnt == 2'(STEPS - 1)) ? DONE : BUSY;
      out_valid <= (cnt == 2'(STEPS - 1));
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
endmodule
